// File: rtl/elastic_pipe_reg_pkg.sv
// Shared constants and the count-width helper for elastic_pipe_reg.
package elastic_pipe_reg_pkg;

  localparam int unsigned DEFAULT_WL = 8;

  // Ceiling log2 with a floor of 1 so a derived width is never zero.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/elastic_pipe_stage.sv
// One valid+data stage: loads on load, valid cleared by clr, data held when idle.
module elastic_pipe_stage
  import elastic_pipe_reg_pkg::*;
#(
  parameter int unsigned WL = DEFAULT_WL
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          load,
  input  logic          in_valid,
  input  logic [WL-1:0] in_data,
  output logic          valid,
  output logic [WL-1:0] data
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else begin
      if (clr)       valid <= 1'b0;
      else if (load) valid <= in_valid;
      if (!clr && load && in_valid) data <= in_data;
    end
  end

endmodule

// File: rtl/elastic_pipe_reg.sv
// DEPTH-stage elastic pipeline register with bubble collapse, flush and occupancy.
// Define ELASTIC_PIPE_REG_SKID_EN to add a skid slot that registers in_ready.
module elastic_pipe_reg
  import elastic_pipe_reg_pkg::*;
#(
  parameter  int unsigned WL    = DEFAULT_WL,
  parameter  int unsigned DEPTH = 3,
  localparam int unsigned CW    = clog2(DEPTH + 2)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [WL-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [WL-1:0] out_data,
  output logic [CW-1:0] count
);

  logic [DEPTH-1:0] valid;
  logic [DEPTH-1:0] adv;
  logic [WL-1:0]    data [DEPTH];
  logic [DEPTH-1:0] stage_in_valid;
  logic [WL-1:0]    stage_in_data [DEPTH];
  logic             s0_valid;
  logic [WL-1:0]    s0_data;
  logic             in_xfer;
  logic             out_xfer;

  // A stage may advance when it is empty or everything ahead of it moves.
  always_comb begin
    adv = '0;
    adv[DEPTH-1] = ~valid[DEPTH-1] | out_ready;
    for (int unsigned k = 1; k < DEPTH; k++) begin
      adv[DEPTH-1-k] = ~valid[DEPTH-1-k] | adv[DEPTH-k];
    end
  end

`ifdef ELASTIC_PIPE_REG_SKID_EN
  logic          skid_valid;
  logic [WL-1:0] skid_data;

  assign in_ready = ~skid_valid & ~clr;
  assign in_xfer  = in_valid & in_ready;
  // The skid word always enters stage 0 before any newer input.
  assign s0_valid = skid_valid | in_xfer;
  assign s0_data  = skid_valid ? skid_data : in_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (clr) begin
      skid_valid <= 1'b0;
    end else if (skid_valid) begin
      if (adv[0]) skid_valid <= 1'b0;
    end else if (in_xfer && !adv[0]) begin
      skid_valid <= 1'b1;
      skid_data  <= in_data;
    end
  end
`else
  assign in_ready = adv[0] & ~clr;
  assign in_xfer  = in_valid & in_ready;
  assign s0_valid = in_xfer;
  assign s0_data  = in_data;
`endif

  assign out_xfer  = out_valid & out_ready;
  assign out_valid = valid[DEPTH-1];
  assign out_data  = data[DEPTH-1];

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    if (g == 0) begin : g_first
      assign stage_in_valid[g] = s0_valid;
      assign stage_in_data[g]  = s0_data;
    end else begin : g_rest
      assign stage_in_valid[g] = valid[g-1];
      assign stage_in_data[g]  = data[g-1];
    end

    elastic_pipe_stage #(.WL(WL)) u_stage (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr),
      .load     (adv[g]),
      .in_valid (stage_in_valid[g]),
      .in_data  (stage_in_data[g]),
      .valid    (valid[g]),
      .data     (data[g])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else begin
      case ({in_xfer, out_xfer})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
